reload_timer: RTL and testbench
===============================

// Module: reload_timer
// PURPOSE
//  Parametrised countdown timer for traffic-light phase timing. Successor to the 4-bit one-shot timer.
//  Adds configurable width, a tick prescaler, auto-reload (periodic) mode, hold/pause and abort.
//  Sits between the phase FSM (start/abort/hold) and the 1 Hz enable generator (oneHz_enable).
//  Generates a single-cycle expired pulse per elapsed period.
// PARAMETERS
//  WIDTH     4   bit width of Value and remaining (max period 2**WIDTH-1 ticks)
//  TICK_DIV  1   oneHz_enable pulses per timer decrement (>=1); 1 = no prescale
// PORTS
//  clk           in   1      system clock; all state updates on rising edge
//  Reset_Sync    in   1      reset; asynchronous, active-high
//  oneHz_enable  in   1      tick strobe, one clk wide per tick
//  start_timer   in   1      load Value and start; restarts if already running
//  Value         in   WIDTH  period in ticks; sampled only on start_timer
//  reload_mode   in   1      0 = one-shot, 1 = auto-reload; sampled on start_timer
//  hold          in   1      1 = freeze count (ticks ignored)
//  abort         in   1      stop immediately, no expired pulse
//  expired       out  1      one-cycle pulse when count reaches 0
//  busy          out  1      1 in RUN or HOLD
//  remaining     out  WIDTH  current count
// BEHAVIOUR
//  Reset (async, any time incl. mid-count): state=IDLE, count=0, reload_reg=0, prescale=0,
//   mode_reg=0. Outputs: expired=0, busy=0, remaining=0.
//  States: IDLE, RUN, HOLD. busy = (state!=IDLE). remaining = count register.
//  Priority per cycle: abort > start_timer > hold > tick.
//  abort: any state -> IDLE, count=0, prescale=0; expired=0 next cycle; overrides a coincident expiry.
//  start_timer (not abort):
//   - Latch reload_reg=Value and mode_reg=reload_mode; count=Value; prescale=0.
//   - Any coincident tick is discarded.
//   - Value!=0 -> RUN.
//   - Value==0 -> stay/return IDLE, expired=1 next cycle (zero-length period).
//  RUN:
//   - hold=1 -> HOLD; the tick in that cycle is ignored.
//   - Otherwise, on oneHz_enable: if prescale==TICK_DIV-1, then prescale=0 and decrement; else prescale+1.
//   - Decrement with count==1:
//     - Register expired=1 for the following cycle.
//     - mode_reg=0: count=0, -> IDLE.
//     - mode_reg=1: count=reload_reg, stay RUN; the next period begins immediately, no dead tick.
//   - Decrement with count>1: count-1.
//  HOLD: count and prescale frozen; ticks ignored; hold=0 -> RUN the next cycle. start/abort still act.
//  Latency: expired asserts exactly N*TICK_DIV ticks after start (N=Value).
//   It is registered, so it is high in the cycle after the final tick's clock edge.
//  expired is never high 2 consecutive cycles, except periodic mode when Value=1, TICK_DIV=1
//   and oneHz_enable is held high continuously.
//  count never wraps: decrement from 1 only ever goes to 0 or reload_reg; no underflow from 0.
//  Value/reload_mode changes while RUN have no effect until the next start_timer.
//  oneHz_enable high in IDLE: no effect.
// TESTING (WIDTH=4, clk period 10, oneHz_enable every 2nd cycle unless stated)
//  1 Reset: assert Reset_Sync mid-clock while RUN with count=5.
//    -> expired=0, busy=0, remaining=0 immediately, before the next edge.
//  2 One-shot, TICK_DIV=1: Value=6, start 1 cycle.
//    -> remaining 6,5,4,3,2,1,0 on successive ticks; expired one pulse after 6th tick; busy drops with it.
//  3 Periodic: Value=3, reload_mode=1.
//    -> expired pulse every 3 ticks (3 pulses in 9 ticks); remaining 3,2,1,3,2,1...; busy stays 1.
//  4 Hold/abort: Value=5, hold=1 for 4 ticks after 2nd tick.
//    -> remaining frozen at 3; expiry delayed by exactly the held ticks.
//    Then abort at remaining=1 coincident with tick -> no expired, IDLE, remaining=0.
//  5 Restart/edge: start Value=4 then restart with Value=2 at remaining=1 on a tick cycle.
//    -> remaining=2, tick discarded, expired 2 ticks later.
//    Start with Value=0 -> single expired pulse, busy stays 0.
//  6 Prescale, TICK_DIV=3: Value=2.
//    -> expired after exactly 6 oneHz_enable pulses; prescale restarts on start_timer.

Source files
------------

// File: rtl/reload_timer.sv
// reload_timer: countdown timer for traffic-light phase timing.
//
// The timer counts ticks of an external enable strobe. A prescaler divides
// that strobe by TICK_DIV. The timer can run once (one-shot) or repeat its
// period automatically (auto-reload). It can be paused with hold and
// cancelled with abort. Each elapsed period produces a one-cycle expired
// pulse.
//
// Parameters
//   WIDTH     width of Value and remaining; the longest period is 2**WIDTH-1 ticks
//   TICK_DIV  number of oneHz_enable pulses per decrement (>= 1)
//
// Ports
//   clk           system clock, rising edge
//   Reset_Sync    asynchronous, active-high reset
//   oneHz_enable  tick strobe, one clk wide
//   start_timer   load Value and start counting; restarts a running timer
//   Value         period in ticks; sampled only when start_timer is high
//   reload_mode   0 = one-shot, 1 = auto-reload; sampled with start_timer
//   hold          freezes the count while high
//   abort         stops the timer at once and suppresses any expiry
//   expired       registered one-cycle pulse at the end of each period
//   busy          high while the timer is running or held
//   remaining     current count
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | not counting; remaining is 0 (or a just-loaded zero period)
// RUN   | counting ticks through the prescaler
// HOLD  | paused; count and prescaler frozen, ticks ignored

module reload_timer #(
   parameter int WIDTH    = 4,
   parameter int TICK_DIV = 1
) (
   input  logic             clk,
   input  logic             Reset_Sync,
   input  logic             oneHz_enable,
   input  logic             start_timer,
   input  logic [WIDTH-1:0] Value,
   input  logic             reload_mode,
   input  logic             hold,
   input  logic             abort,
   output logic             expired,
   output logic             busy,
   output logic [WIDTH-1:0] remaining
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] reload_reg;
   logic             mode_reg;
   logic [PW-1:0]    prescale;

   always_ff @(posedge clk or posedge Reset_Sync) begin
      if (Reset_Sync) begin
         state      <= IDLE;
         count      <= '0;
         reload_reg <= '0;
         mode_reg   <= 1'b0;
         prescale   <= '0;
         expired    <= 1'b0;
      end else begin
         expired <= 1'b0;
         if (abort) begin
            state    <= IDLE;
            count    <= '0;
            prescale <= '0;
         end else if (start_timer) begin
            // A tick arriving in the same cycle as start is dropped, so the
            // period always begins cleanly on the following tick.
            reload_reg <= Value;
            mode_reg   <= reload_mode;
            count      <= Value;
            prescale   <= '0;
            if (Value != '0) begin
               state <= RUN;
            end else begin
               state   <= IDLE;
               expired <= 1'b1;
            end
         end else begin
            case (state)
               RUN: begin
                  if (hold) begin
                     state <= HOLD;
                  end else if (oneHz_enable) begin
                     if (prescale == PRE_LAST) begin
                        prescale <= '0;
                        if (count == WIDTH'(1)) begin
                           expired <= 1'b1;
                           // Auto-reload starts the next period right away.
                           if (mode_reg) begin
                              count <= reload_reg;
                           end else begin
                              count <= '0;
                              state <= IDLE;
                           end
                        end else if (count != '0) begin
                           count <= count - WIDTH'(1);
                        end
                     end else begin
                        prescale <= prescale + PW'(1);
                     end
                  end
               end
               HOLD: begin
                  if (!hold) state <= RUN;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign busy      = (state != IDLE);
   assign remaining = count;

endmodule

// File: tb/tb_reload_timer.sv
// Bench for reload_timer. Two instances share the same stimulus. One uses
// TICK_DIV=1 and the other TICK_DIV=3. Both are checked every cycle against
// a model that tracks the ticks elapsed in the current period. Directed
// scenarios with literal expectations pin that model. A randomized phase
// follows them.

module tb_reload_timer;

   localparam int W    = 4;
   localparam int DIV0 = 1;
   localparam int DIV1 = 3;

   logic         clk          = 1'b0;
   logic         Reset_Sync   = 1'b1;
   logic         oneHz_enable = 1'b0;
   logic         start_timer  = 1'b0;
   logic [W-1:0] Value        = '0;
   logic         reload_mode  = 1'b0;
   logic         hold         = 1'b0;
   logic         abort        = 1'b0;
   logic         exp_o  [2];
   logic         busy_o [2];
   logic [W-1:0] rem_o  [2];

   int total = 0;
   int bad   = 0;
   bit cmp_en = 1'b0;
   int tick_mode = 0;
   int tick_ph = 0;

   reload_timer #(.WIDTH(W), .TICK_DIV(DIV0)) u_dut0 (
      .clk(clk), .Reset_Sync(Reset_Sync), .oneHz_enable(oneHz_enable),
      .start_timer(start_timer), .Value(Value), .reload_mode(reload_mode),
      .hold(hold), .abort(abort), .expired(exp_o[0]), .busy(busy_o[0]),
      .remaining(rem_o[0]));

   reload_timer #(.WIDTH(W), .TICK_DIV(DIV1)) u_dut1 (
      .clk(clk), .Reset_Sync(Reset_Sync), .oneHz_enable(oneHz_enable),
      .start_timer(start_timer), .Value(Value), .reload_mode(reload_mode),
      .hold(hold), .abort(abort), .expired(exp_o[1]), .busy(busy_o[1]),
      .remaining(rem_o[1]));

   initial forever #5 clk = ~clk;

   // Tick strobe: alternate cycles, random, or held high continuously.
   initial forever begin
      @(negedge clk);
      case (tick_mode)
         0: begin
            tick_ph++;
            oneHz_enable = (tick_ph % 2 == 1);
         end
         1: oneHz_enable = ($urandom_range(0, 1) == 1);
         default: oneHz_enable = 1'b1;
      endcase
   end

   function automatic int dv(input int k);
      return (k == 0) ? DIV0 : DIV1;
   endfunction

   // Model: a period of N ticks lasts N*div strobes. The bench counts
   // strobes elapsed in the current period and derives remaining from it.
   bit m_run [2], m_pause [2], m_periodic [2], m_exp [2];
   int m_period [2], m_elapsed [2];

   always @(posedge clk or posedge Reset_Sync) begin
      for (int k = 0; k < 2; k++) begin
         if (Reset_Sync) begin
            m_run[k] = 0; m_pause[k] = 0; m_periodic[k] = 0; m_exp[k] = 0;
            m_period[k] = 0; m_elapsed[k] = 0;
         end else begin
            m_exp[k] = 0;
            if (abort) begin
               m_run[k] = 0; m_pause[k] = 0;
            end else if (start_timer) begin
               m_period[k]   = int'(Value);
               m_periodic[k] = reload_mode;
               m_elapsed[k]  = 0;
               m_pause[k]    = 0;
               m_run[k]      = (Value != 0);
               m_exp[k]      = (Value == 0);
            end else if (m_run[k] && m_pause[k]) begin
               if (!hold) m_pause[k] = 0;
            end else if (m_run[k]) begin
               if (hold) m_pause[k] = 1;
               else if (oneHz_enable) begin
                  m_elapsed[k]++;
                  if (m_elapsed[k] == m_period[k] * dv(k)) begin
                     m_exp[k] = 1;
                     m_elapsed[k] = 0;
                     if (!m_periodic[k]) m_run[k] = 0;
                  end
               end
            end
         end
      end
   end

   function automatic int m_rem(input int k);
      return m_run[k] ? (m_period[k] - m_elapsed[k] / dv(k)) : 0;
   endfunction

   task automatic chk(input string nm, input int act, input int want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, want, $time);
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (!Reset_Sync && cmp_en) begin
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("expired[%0d]", k), int'(exp_o[k]), int'(m_exp[k]));
            chk($sformatf("busy[%0d]", k), int'(busy_o[k]), int'(m_run[k]));
            chk($sformatf("remaining[%0d]", k), int'(rem_o[k]), m_rem(k));
         end
      end
   end

   task automatic nxt();
      @(negedge clk);
      #1;
   endtask

   task automatic timeout(input string nm);
      total++;
      bad++;
      $display("FAIL %s: timed out waiting for the DUT", nm);
   endtask

   task automatic wait_ticks(input int n);
      int t = 0;
      for (int i = 0; i < 400 && t < n; i++) begin
         @(posedge clk);
         if (oneHz_enable) t++;
         @(negedge clk);
         #1;
      end
      if (t < n) timeout("wait_ticks");
   endtask

   task automatic run_until_exp(input int k, output int t);
      bit found = 0;
      t = 0;
      for (int i = 0; i < 400 && !found; i++) begin
         @(posedge clk);
         if (oneHz_enable) t++;
         @(negedge clk);
         #1;
         if (exp_o[k]) found = 1;
      end
      if (!found) timeout("run_until_exp");
   endtask

   task automatic wait_rem_tick(input int r, input string nm);
      bit hit = 0;
      for (int i = 0; i < 400 && !hit; i++) begin
         nxt();
         if (int'(rem_o[0]) == r && oneHz_enable) hit = 1;
      end
      if (!hit) timeout(nm);
   endtask

   task automatic start(input int v, input bit m);
      Value = W'(v);
      reload_mode = m;
      start_timer = 1;
      nxt();
      start_timer = 0;
   endtask

   task automatic all_zero(input string nm);
      for (int k = 0; k < 2; k++) begin
         chk({nm, "_expired"}, int'(exp_o[k]), 0);
         chk({nm, "_busy"}, int'(busy_o[k]), 0);
         chk({nm, "_remaining"}, int'(rem_o[k]), 0);
      end
   endtask

   initial begin
      int t;
      int pulses;
      bit dropped;
      int r;

      repeat (2) @(negedge clk);
      all_zero("reset");
      #2 Reset_Sync = 0;
      cmp_en = 1;
      nxt();

      // One-shot, Value=6.
      start(6, 0);
      chk("os_rem_after_start", int'(rem_o[0]), 6);
      chk("os_busy_after_start", int'(busy_o[0]), 1);
      run_until_exp(0, t);
      chk("os_ticks_to_expiry", t, 6);
      chk("os_busy_with_expiry", int'(busy_o[0]), 0);
      chk("os_rem_with_expiry", int'(rem_o[0]), 0);

      // Periodic, Value=3: three pulses in nine ticks, busy never drops.
      start(3, 1);
      pulses = 0; dropped = 0; t = 0;
      for (int i = 0; i < 400 && t < 9; i++) begin
         @(posedge clk);
         if (oneHz_enable) t++;
         @(negedge clk);
         #1;
         if (exp_o[0]) pulses++;
         if (!busy_o[0]) dropped = 1;
      end
      chk("per_pulses_in_9", pulses, 3);
      chk("per_busy_dropped", int'(dropped), 0);
      abort = 1; nxt(); abort = 0;

      // Hold for four ticks after the second tick, then abort at remaining=1.
      start(5, 0);
      wait_ticks(2);
      chk("hold_rem_before", int'(rem_o[0]), 3);
      hold = 1;
      wait_ticks(4);
      chk("hold_rem_frozen", int'(rem_o[0]), 3);
      chk("hold_busy", int'(busy_o[0]), 1);
      hold = 0;
      wait_rem_tick(1, "abort_wait");
      abort = 1; nxt(); abort = 0;
      chk("abort_expired", int'(exp_o[0]), 0);
      chk("abort_busy", int'(busy_o[0]), 0);
      chk("abort_rem", int'(rem_o[0]), 0);

      // Restart with Value=2 on a tick cycle at remaining=1.
      start(4, 0);
      wait_rem_tick(1, "restart_wait");
      start(2, 0);
      chk("restart_rem", int'(rem_o[0]), 2);
      run_until_exp(0, t);
      chk("restart_ticks", t, 2);

      // A zero-length period gives one pulse and never sets busy.
      start(0, 0);
      chk("zero_expired", int'(exp_o[0]), 1);
      chk("zero_busy", int'(busy_o[0]), 0);
      nxt();
      chk("zero_expired_once", int'(exp_o[0]), 0);

      // Prescale by 3: a restart clears partial prescale progress.
      start(2, 0);
      wait_ticks(2);
      start(2, 0);
      run_until_exp(1, t);
      chk("pre3_ticks", t, 6);

      // Asynchronous reset mid-clock while counting at remaining=5.
      start(8, 0);
      for (int i = 0; i < 400 && int'(rem_o[0]) != 5; i++) nxt();
      chk("rst_precond_rem", int'(rem_o[0]), 5);
      @(posedge clk);
      #3 Reset_Sync = 1;
      #1 all_zero("async_reset");
      @(negedge clk);
      #2 Reset_Sync = 0;
      nxt();

      // Randomized phase.
      for (int c = 0; c < 3000; c++) begin
         if (c % 250 == 0) tick_mode = (c / 250) % 3;
         nxt();
         start_timer = 0;
         abort = 0;
         r = $urandom_range(0, 99);
         if (r < 3) abort = 1;
         else if (r < 12 || r == 99) begin
            start_timer = 1;
            abort = (r == 99);
            if ($urandom_range(0, 2) == 0) Value = W'($urandom_range(0, 2));
            else Value = W'($urandom_range(0, 15));
            reload_mode = ($urandom_range(0, 1) == 1);
         end else if (r < 15) begin
            Value = W'($urandom_range(0, 15));
            reload_mode = ($urandom_range(0, 1) == 1);
         end
         if ($urandom_range(0, 9) == 0) hold = ~hold;
         if (c % 997 == 500) begin
            Reset_Sync = 1;
            #1 all_zero("rand_reset");
            @(posedge clk);
            #2 Reset_Sync = 0;
         end
      end
      start_timer = 0;
      abort = 0;
      nxt();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
